// File: rtl/capsense_scan_seq_pkg.sv
// ---------------------------------------------------------------------------
// capsense_scan_seq_pkg
// Shared definitions for the capacitive-sense scan sequencer:
//   - scan_state_t    : sequencer FSM state enumeration
//   - DEF_*           : default values for the sequencer parameters
//   - TIMEOUT_RESULT  : all-ones pattern reported when a measurement times out
//   - idx_width()     : sensor index width, never narrower than one bit
// Optional feature macro used by the sequencer: CAPSENSE_SCAN_TIMEOUT_EN
// ---------------------------------------------------------------------------
package capsense_scan_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_CAPTURE,
        ST_RELEASE,
        ST_DONE
    } scan_state_t;

    localparam int DEF_NUM_SENSORS    = 8;
    localparam int DEF_CNT_WIDTH      = 16;
    localparam int DEF_SETTLE_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    // Wide enough for the largest raw count; truncated to CNT_WIDTH at use.
    localparam logic [63:0] TIMEOUT_RESULT = '1;

    // A single sensor still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/capsense_scan_timer.sv
// ---------------------------------------------------------------------------
// capsense_scan_timer
// Loadable down-counter with a zero flag. Counting stops at zero.
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset (counter cleared to zero)
//   load       : load load_value this cycle (takes priority over counting)
//   load_value : value loaded into the counter
//   count_en   : decrement by one while not already zero
//   zero       : high while the counter holds zero
// ---------------------------------------------------------------------------
module capsense_scan_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over decrement so a fresh interval always starts cleanly,
    // and the counter saturates at zero so a late reader still sees the flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count_en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/capsense_scan_seq.sv
// ---------------------------------------------------------------------------
// capsense_scan_seq
// Walks through NUM_SENSORS capacitive sensors: connect and settle each one,
// run a measurement on the external measure channel, publish the raw count as
// a one-cycle result strobe, release the sensor, then move on to the next.
// Optional feature macro: CAPSENSE_SCAN_TIMEOUT_EN adds a measurement
// watchdog that forces an all-ones result and sets a sticky timeout_err.
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   scan_go     : start one full scan (honoured only while idle)
//   scan_abort  : abandon the scan, back to idle on the next edge
//   meas_start  : request to the measure channel
//   meas_done   : measure channel finished, held until meas_start falls
//   raw_count   : measured count, valid while meas_done is high
//   sns_en      : connect the selected sensor
//   sns_idx     : index of the selected sensor
//   res_valid   : one-cycle result strobe
//   res_idx     : sensor index of the latest result
//   res_data    : latest result count
//   busy        : sequencer not idle
//   scan_done   : one-cycle strobe at the end of a completed scan
//   timeout_err : sticky measurement timeout flag (0 without the macro)
// ---------------------------------------------------------------------------
module capsense_scan_seq
    import capsense_scan_seq_pkg::*;
#(
    parameter int NUM_SENSORS    = DEF_NUM_SENSORS,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W         = idx_width(NUM_SENSORS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 scan_go,
    input  logic                 scan_abort,
    output logic                 meas_start,
    input  logic                 meas_done,
    input  logic [CNT_WIDTH-1:0] raw_count,
    output logic                 sns_en,
    output logic [IDX_W-1:0]     sns_idx,
    output logic                 res_valid,
    output logic [IDX_W-1:0]     res_idx,
    output logic [CNT_WIDTH-1:0] res_data,
    output logic                 busy,
    output logic                 scan_done,
    output logic                 timeout_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SENSORS - 1);

    scan_state_t state;

    logic settle_load;
    logic settle_count;
    logic settle_zero;

    // The settle timer is loaded with SETTLE_CYCLES-1 on every entry into
    // SETTLE; SETTLE exits on the cycle the timer reads zero, which gives
    // exactly SETTLE_CYCLES cycles of settling.
    always_comb begin
        settle_load  = 1'b0;
        settle_count = 1'b0;
        if (state == ST_IDLE && scan_go && !scan_abort) begin
            settle_load = 1'b1;
        end
        if (state == ST_RELEASE && !meas_done && sns_idx != LAST_IDX) begin
            settle_load = 1'b1;
        end
        if (state == ST_SETTLE) begin
            settle_count = 1'b1;
        end
    end

    capsense_scan_timer #(
        .WIDTH(8)
    ) u_settle_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (settle_load),
        .load_value (8'(SETTLE_CYCLES - 1)),
        .count_en   (settle_count),
        .zero       (settle_zero)
    );

`ifdef CAPSENSE_SCAN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic wd_load;
    logic wd_count;
    logic wd_zero;
    logic timeout_flag;

    // The watchdog starts with the measurement; when it reads zero the
    // measurement has run TIMEOUT_CYCLES cycles without meas_done.
    always_comb begin
        wd_load  = (state == ST_SETTLE) && settle_zero;
        wd_count = (state == ST_MEASURE);
    end

    capsense_scan_timer #(
        .WIDTH(WD_W)
    ) u_watchdog_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (wd_load),
        .load_value (WD_W'(TIMEOUT_CYCLES - 1)),
        .count_en   (wd_count),
        .zero       (wd_zero)
    );

    assign timeout_err = timeout_flag;
`else
    assign timeout_err = 1'b0;
`endif

    // Sequencer FSM. Every output is a flop set on the transition into the
    // state that owns it, so outputs change only on clock edges (or reset).
    // Abort overrides everything and returns to idle without a scan_done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            meas_start <= 1'b0;
            sns_en     <= 1'b0;
            sns_idx    <= '0;
            res_valid  <= 1'b0;
            res_idx    <= '0;
            res_data   <= '0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
`ifdef CAPSENSE_SCAN_TIMEOUT_EN
            timeout_flag <= 1'b0;
`endif
        end else if (scan_abort) begin
            state      <= ST_IDLE;
            meas_start <= 1'b0;
            sns_en     <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (scan_go) begin
                        state   <= ST_SETTLE;
                        sns_idx <= '0;
                        sns_en  <= 1'b1;
                        busy    <= 1'b1;
`ifdef CAPSENSE_SCAN_TIMEOUT_EN
                        timeout_flag <= 1'b0;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (settle_zero) begin
                        state      <= ST_MEASURE;
                        meas_start <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    // A meas_done already high on entry is taken as a result.
                    if (meas_done) begin
                        state      <= ST_CAPTURE;
                        meas_start <= 1'b0;
                        res_valid  <= 1'b1;
                        res_idx    <= sns_idx;
                        res_data   <= raw_count;
`ifdef CAPSENSE_SCAN_TIMEOUT_EN
                    end else if (wd_zero) begin
                        state        <= ST_CAPTURE;
                        meas_start   <= 1'b0;
                        res_valid    <= 1'b1;
                        res_idx      <= sns_idx;
                        res_data     <= CNT_WIDTH'(TIMEOUT_RESULT);
                        timeout_flag <= 1'b1;
`endif
                    end
                end
                ST_CAPTURE: begin
                    state     <= ST_RELEASE;
                    res_valid <= 1'b0;
                    sns_en    <= 1'b0;
                end
                ST_RELEASE: begin
                    // Wait for the channel to drop its done flag so the next
                    // measurement cannot see a stale completion.
                    if (!meas_done) begin
                        if (sns_idx == LAST_IDX) begin
                            state     <= ST_DONE;
                            scan_done <= 1'b1;
                        end else begin
                            state   <= ST_SETTLE;
                            sns_idx <= sns_idx + IDX_W'(1);
                            sns_en  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    scan_done <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
